tft_rect_fill: RTL and testbench

- Parametrised successor of the fixed-size player-square drawer.
- Fills an arbitrary axis-aligned rectangle on the TFT with a runtime colour.
- Sequence per fill: CASET/PASET/RAMWR window header, then exactly w*h pixels in the configured pixel format.
- Sits between game logic (maze, player, erase) and the shared TFT byte transmitter; clips to panel bounds and reports completion with a done pulse.

---
 rtl/tft_pkg.sv | 17 +
 rtl/tft_window_hdr.sv | 63 ++++++
 rtl/tft_rect_fill.sv | 188 ++++++++++++++++++
 tb/tb_tft_rect_fill.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_pkg.sv
// Shared constants and state encoding for the TFT fill/blit engines.
package tft_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int unsigned HDR_LEN = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PIX  = 2'd2,
        DONE = 2'd3
    } fill_state_t;

endpackage

// File: rtl/tft_window_hdr.sv
// Emits the CASET/PASET/RAMWR window header, one byte per issue slot.
// The parent registers the chosen byte onto the TFT bus.
module tft_window_hdr (
    input  logic        clk,
    input  logic        rst,
    input  logic        active,
    input  logic [15:0] x_start,
    input  logic [15:0] x_end,
    input  logic [15:0] y_start,
    input  logic [15:0] y_end,
    input  logic        tft_busy,
    input  logic        tft_transmit,
    output logic        issue,
    output logic        dc,
    output logic [7:0]  data,
    output logic        hdr_done
);
    import tft_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(HDR_LEN - 1);

    logic [3:0] idx_r;

    // Issue slot opens only when the transmitter is idle and no strobe is in flight
    always_comb begin
        issue    = active & ~tft_busy & ~tft_transmit;
        hdr_done = issue & (idx_r == LAST_IDX);
    end

    // Header byte table indexed by position
    always_comb begin
        dc   = 1'b1;
        data = 8'h00;
        case (idx_r)
            4'd0:    begin dc = 1'b0; data = CMD_CASET; end
            4'd1:    data = x_start[15:8];
            4'd2:    data = x_start[7:0];
            4'd3:    data = x_end[15:8];
            4'd4:    data = x_end[7:0];
            4'd5:    begin dc = 1'b0; data = CMD_PASET; end
            4'd6:    data = y_start[15:8];
            4'd7:    data = y_start[7:0];
            4'd8:    data = y_end[15:8];
            4'd9:    data = y_end[7:0];
            4'd10:   begin dc = 1'b0; data = CMD_RAMWR; end
            default: begin dc = 1'b1; data = 8'h00; end
        endcase
    end

    // Byte index; rewinds whenever the sequencer is inactive or completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r <= 4'd0;
        end else if (!active) begin
            idx_r <= 4'd0;
        end else if (issue) begin
            idx_r <= hdr_done ? 4'd0 : idx_r + 4'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

endmodule

// File: rtl/tft_rect_fill.sv
// Clipped rectangle fill: window header followed by w_eff*h_eff pixels
// of a single colour, paced by the shared TFT byte transmitter.
module tft_rect_fill #(
    parameter int MAX_W       = 320,
    parameter int MAX_H       = 240,
    parameter int PIXEL_BYTES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  x,
    input  logic [8:0]  y,
    input  logic [8:0]  w,
    input  logic [8:0]  h,
    input  logic [23:0] color,
    input  logic        tft_busy,
    output logic        tft_dc,
    output logic [7:0]  tft_data,
    output logic        tft_transmit,
    output logic        busy,
    output logic        done
);
    import tft_pkg::*;

    generate
        if (PIXEL_BYTES != 2 && PIXEL_BYTES != 3) begin : g_bad_pixel_bytes
            $error("tft_rect_fill: PIXEL_BYTES must be 2 or 3");
        end
    endgenerate

    localparam logic [15:0] X_MAX     = 16'(MAX_W - 1);
    localparam logic [15:0] Y_MAX     = 16'(MAX_H - 1);
    localparam logic [1:0]  LAST_BYTE = 2'(PIXEL_BYTES - 1);

    fill_state_t state_r;
    logic [15:0] x_r, y_r, x_end_r, y_end_r;
    logic [23:0] color_r;
    logic [16:0] total_r, pix_cnt_r;
    logic [1:0]  byte_idx_r;
    logic        busy_r, done_r, tft_transmit_r, tft_dc_r;
    logic [7:0]  tft_data_r;

    logic [15:0] x_in_s, y_in_s, x_last_s, y_last_s, x_end_s, y_end_s;
    logic [15:0] w_eff_s, h_eff_s;
    logic [16:0] total_s, pix_cnt_next_s;
    logic        empty_s, pix_issue_s, pix_last_byte_s;
    logic [7:0]  pix_data_s;
    logic        hdr_issue_s, hdr_dc_s, hdr_done_s;
    logic [7:0]  hdr_data_s;

    // Clip the requested rectangle against the panel at latch time
    always_comb begin
        x_in_s   = {7'd0, x};
        y_in_s   = {7'd0, y};
        x_last_s = x_in_s + {7'd0, w} - 16'd1;
        y_last_s = y_in_s + {7'd0, h} - 16'd1;
        if (x_last_s > X_MAX) begin
            x_end_s = X_MAX;
        end else begin
            x_end_s = x_last_s;
        end
        if (y_last_s > Y_MAX) begin
            y_end_s = Y_MAX;
        end else begin
            y_end_s = y_last_s;
        end
        empty_s = (w == 9'd0) | (h == 9'd0) | (x_in_s > X_MAX) | (y_in_s > Y_MAX);
        w_eff_s = x_end_s - x_in_s + 16'd1;
        h_eff_s = y_end_s - y_in_s + 16'd1;
        total_s = 17'(w_eff_s) * 17'(h_eff_s);
    end

    // Pixel byte selection, most significant colour byte first
    always_comb begin
        pix_issue_s     = (state_r == PIX) & ~tft_busy & ~tft_transmit_r;
        pix_last_byte_s = (byte_idx_r == LAST_BYTE);
        pix_cnt_next_s  = pix_cnt_r + 17'd1;
        case (byte_idx_r)
            2'd0:    pix_data_s = (PIXEL_BYTES == 3) ? color_r[23:16] : color_r[15:8];
            2'd1:    pix_data_s = (PIXEL_BYTES == 3) ? color_r[15:8] : color_r[7:0];
            2'd2:    pix_data_s = color_r[7:0];
            default: pix_data_s = 8'h00;
        endcase
    end

    tft_window_hdr u_hdr (
        .clk          (clk),
        .rst          (rst),
        .active       (state_r == HDR),
        .x_start      (x_r),
        .x_end        (x_end_r),
        .y_start      (y_r),
        .y_end        (y_end_r),
        .tft_busy     (tft_busy),
        .tft_transmit (tft_transmit_r),
        .issue        (hdr_issue_s),
        .dc           (hdr_dc_s),
        .data         (hdr_data_s),
        .hdr_done     (hdr_done_s)
    );

    // Fill sequencer with registered TFT and handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            x_r            <= 16'd0;
            y_r            <= 16'd0;
            x_end_r        <= 16'd0;
            y_end_r        <= 16'd0;
            color_r        <= 24'd0;
            total_r        <= 17'd0;
            pix_cnt_r      <= 17'd0;
            byte_idx_r     <= 2'd0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            tft_transmit_r <= 1'b0;
            tft_dc_r       <= 1'b0;
            tft_data_r     <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    tft_transmit_r <= 1'b0;
                    done_r         <= 1'b0;
                    if (start) begin
                        x_r        <= x_in_s;
                        y_r        <= y_in_s;
                        x_end_r    <= x_end_s;
                        y_end_r    <= y_end_s;
                        color_r    <= color;
                        total_r    <= total_s;
                        pix_cnt_r  <= 17'd0;
                        byte_idx_r <= 2'd0;
                        busy_r     <= 1'b1;
                        state_r    <= empty_s ? DONE : HDR;
                    end
                end
                HDR: begin
                    tft_transmit_r <= hdr_issue_s;
                    if (hdr_issue_s) begin
                        tft_dc_r   <= hdr_dc_s;
                        tft_data_r <= hdr_data_s;
                    end
                    if (hdr_done_s) begin
                        state_r <= PIX;
                    end
                end
                PIX: begin
                    tft_transmit_r <= pix_issue_s;
                    if (pix_issue_s) begin
                        tft_dc_r   <= 1'b1;
                        tft_data_r <= pix_data_s;
                        if (pix_last_byte_s) begin
                            byte_idx_r <= 2'd0;
                            pix_cnt_r  <= pix_cnt_next_s;
                            if (pix_cnt_next_s == total_r) begin
                                state_r <= DONE;
                            end
                        end else begin
                            byte_idx_r <= byte_idx_r + 2'd1;
                        end
                    end
                end
                DONE: begin
                    tft_transmit_r <= 1'b0;
                    // Completion only once the last byte has left the transmitter
                    if (!tft_transmit_r && !tft_busy) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    busy_r         <= 1'b0;
                    done_r         <= 1'b0;
                    tft_transmit_r <= 1'b0;
                end
            endcase
        end
    end

    assign tft_dc       = tft_dc_r;
    assign tft_data     = tft_data_r;
    assign tft_transmit = tft_transmit_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_tft_rect_fill.sv
// Bench for tft_rect_fill: RGB666 and RGB565 instances, a busy-after-strobe
// transmitter model and a byte-stream reference model.
module tb_tft_rect_fill;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start3 = 1'b0, start2 = 1'b0;
    logic [8:0]  x = '0, y = '0, w = '0, h = '0;
    logic [23:0] color = '0;
    logic        tft_busy3 = 1'b0, tft_busy2 = 1'b0;
    logic        tft_dc3, tft_transmit3, busy3, done3;
    logic        tft_dc2, tft_transmit2, busy2, done2;
    logic [7:0]  tft_data3, tft_data2;

    int checks = 0, passed = 0;
    logic [8:0] cap3[$], cap2[$], exp_q[$];
    int done_cnt3 = 0, done_cnt2 = 0, viol = 0, cnt3 = 0, cnt2 = 0;
    logic prev_tx3 = 1'b0, prev_tx2 = 1'b0;

    always #5 clk = ~clk;

    tft_rect_fill #(.MAX_W(320), .MAX_H(240), .PIXEL_BYTES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .x(x), .y(y), .w(w), .h(h), .color(color),
        .tft_busy(tft_busy3), .tft_dc(tft_dc3), .tft_data(tft_data3),
        .tft_transmit(tft_transmit3), .busy(busy3), .done(done3));

    tft_rect_fill #(.MAX_W(320), .MAX_H(240), .PIXEL_BYTES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .x(x), .y(y), .w(w), .h(h), .color(color),
        .tft_busy(tft_busy2), .tft_dc(tft_dc2), .tft_data(tft_data2),
        .tft_transmit(tft_transmit2), .busy(busy2), .done(done2));

    // Transmitter model: busy for the 3 cycles following each strobe
    always @(posedge clk) begin
        #1;
        if (rst) cnt3 = 0; else if (tft_transmit3) cnt3 = 3; else if (cnt3 > 0) cnt3--;
        if (rst) cnt2 = 0; else if (tft_transmit2) cnt2 = 3; else if (cnt2 > 0) cnt2--;
        tft_busy3 = (cnt3 != 0);
        tft_busy2 = (cnt2 != 0);
    end

    // Byte/done monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (tft_transmit3) begin cap3.push_back({tft_dc3, tft_data3}); if (prev_tx3) viol++; end
            if (tft_transmit2) begin cap2.push_back({tft_dc2, tft_data2}); if (prev_tx2) viol++; end
            if (done3) done_cnt3++;
            if (done2) done_cnt2++;
        end
        prev_tx3 = tft_transmit3;
        prev_tx2 = tft_transmit2;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference model: appends the expected {dc,byte} stream for one fill
    task automatic build_exp(input int fx, fy, fw, fh, input logic [23:0] c, input int pb);
        int xe, ye, npix;
        if (fw == 0 || fh == 0 || fx >= 320 || fy >= 240) return;
        xe = fx + fw - 1; if (xe > 319) xe = 319;
        ye = fy + fh - 1; if (ye > 239) ye = 239;
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, 8'(fx >> 8)}); exp_q.push_back({1'b1, 8'(fx)});
        exp_q.push_back({1'b1, 8'(xe >> 8)}); exp_q.push_back({1'b1, 8'(xe)});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, 8'(fy >> 8)}); exp_q.push_back({1'b1, 8'(fy)});
        exp_q.push_back({1'b1, 8'(ye >> 8)}); exp_q.push_back({1'b1, 8'(ye)});
        exp_q.push_back({1'b0, 8'h2C});
        npix = (xe - fx + 1) * (ye - fy + 1);
        for (int p = 0; p < npix; p++) begin
            if (pb == 3) exp_q.push_back({1'b1, c[23:16]});
            exp_q.push_back({1'b1, c[15:8]});
            exp_q.push_back({1'b1, c[7:0]});
        end
    endtask

    // Index of first difference between captured stream and exp_q, -1 if equal
    function automatic int qdiff(input int sel);
        int n;
        logic [8:0] g;
        n = (sel == 2) ? cap2.size() : cap3.size();
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            g = (sel == 2) ? cap2[i] : cap3[i];
            if (g !== exp_q[i]) return i;
        end
        if (n != exp_q.size()) return (n < exp_q.size()) ? n : exp_q.size();
        return -1;
    endfunction

    // One fill: pulse start, scramble inputs, wait for done (cyc=-1 on timeout)
    task automatic do_fill(input int sel, input int fx, fy, fw, fh, input logic [23:0] fc,
                           output int cyc, output logic busy_after, output logic busy_at_done);
        int budget;
        budget = (11 + fw * fh * 3) * 6 + 40;
        @(negedge clk);
        x = 9'(fx); y = 9'(fy); w = 9'(fw); h = 9'(fh); color = fc;
        cap3.delete(); cap2.delete(); done_cnt3 = 0; done_cnt2 = 0;
        if (sel == 2) start2 = 1'b1; else start3 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; start3 = 1'b0;
        busy_after = (sel == 2) ? busy2 : busy3;
        x = 9'($urandom); y = 9'($urandom); w = 9'($urandom); h = 9'($urandom);
        color = 24'($urandom);
        cyc = 1;
        while (!((sel == 2) ? done2 : done3) && cyc < budget) begin
            @(negedge clk); cyc++;
        end
        busy_at_done = (sel == 2) ? busy2 : busy3;
        if (!((sel == 2) ? done2 : done3)) cyc = -1;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy3, done3, tft_transmit3, tft_dc3, tft_data3} !== 12'h000) $display("FAIL reset_dut3: got %h, need 000", {busy3, done3, tft_transmit3, tft_dc3, tft_data3});
        else passed++;
        checks++;
        if ({busy2, done2, tft_transmit2, tft_dc2, tft_data2} !== 12'h000) $display("FAIL reset_dut2: got %h, need 000", {busy2, done2, tft_transmit2, tft_dc2, tft_data2});
        else passed++;
    endtask

    task automatic test_case1();
        int cyc, d; logic ba, bd;
        logic [8:0] hdr_lit [11] = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h10C,
                                     9'h02B, 9'h100, 9'h114, 9'h100, 9'h115, 9'h02C};
        do_fill(3, 10, 20, 3, 2, 24'hFC003C, cyc, ba, bd);
        exp_q.delete();
        for (int i = 0; i < 11; i++) exp_q.push_back(hdr_lit[i]);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(9'h1FC); exp_q.push_back(9'h100); exp_q.push_back(9'h13C);
        end
        checks++; if (cyc < 0) $display("FAIL case1_timeout: no done within budget"); else passed++;
        d = qdiff(3);
        checks++; if (d != -1) $display("FAIL case1_bytes: first diff at %0d, got %0d bytes, need 29", d, cap3.size()); else passed++;
        checks++; if (ba !== 1'b1) $display("FAIL case1_busy_rise: got %b, need 1", ba); else passed++;
        checks++; if (bd !== 1'b0) $display("FAIL case1_busy_at_done: got %b, need 0", bd); else passed++;
        @(negedge clk);
        checks++; if (done3 !== 1'b0) $display("FAIL case1_done_width: got %b, need 0", done3); else passed++;
        @(negedge clk);
        checks++; if (done_cnt3 != 1) $display("FAIL case1_done_count: got %0d, need 1", done_cnt3); else passed++;
    endtask

    task automatic test_case2();
        int cyc, d; logic ba, bd;
        logic [8:0] lit [13] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h100, 9'h02B, 9'h100,
                                 9'h100, 9'h100, 9'h100, 9'h02C, 9'h1F8, 9'h11F};
        do_fill(2, 0, 0, 1, 1, 24'h00F81F, cyc, ba, bd);
        exp_q.delete();
        for (int i = 0; i < 13; i++) exp_q.push_back(lit[i]);
        checks++; if (cyc < 0) $display("FAIL case2_timeout: no done within budget"); else passed++;
        d = qdiff(2);
        checks++; if (d != -1) $display("FAIL case2_bytes: first diff at %0d, got %0d strobes, need 13", d, cap2.size()); else passed++;
        checks++; if (bd !== 1'b0) $display("FAIL case2_busy_at_done: got %b, need 0", bd); else passed++;
    endtask

    task automatic test_clip();
        int cyc, d; logic ba, bd;
        do_fill(3, 315, 238, 20, 10, 24'h123456, cyc, ba, bd);
        exp_q.delete(); build_exp(315, 238, 20, 10, 24'h123456, 3);
        checks++; if (cyc < 0) $display("FAIL clip_timeout: no done within budget"); else passed++;
        d = qdiff(3);
        checks++; if (d != -1) $display("FAIL clip_bytes: first diff at %0d, got %0d bytes, need %0d", d, cap3.size(), exp_q.size()); else passed++;
        checks++;
        if (cap3.size() < 11) $display("FAIL clip_end_bytes: got only %0d bytes, need header", cap3.size());
        else if ({cap3[3], cap3[4], cap3[8], cap3[9]} !== {9'h101, 9'h13F, 9'h100, 9'h1EF})
            $display("FAIL clip_end_bytes: got %h, need %h", {cap3[3], cap3[4], cap3[8], cap3[9]}, {9'h101, 9'h13F, 9'h100, 9'h1EF});
        else passed++;
        checks++; if (cap3.size() != 11 + 30) $display("FAIL clip_pixels: got %0d bytes, need 41", cap3.size()); else passed++;
    endtask

    task automatic test_empty();
        int cyc; logic ba, bd;
        int ex [3] = '{10, 400, 5};
        int ew [3] = '{0, 4, 4};
        int eh [3] = '{3, 3, 0};
        for (int i = 0; i < 3; i++) begin
            do_fill((i == 2) ? 2 : 3, ex[i], 7, ew[i], eh[i], 24'hABCDEF, cyc, ba, bd);
            checks++; if (cyc != 2) $display("FAIL empty%0d_latency: got %0d, need 2", i, cyc); else passed++;
            @(negedge clk);
            checks++; if (cap3.size() + cap2.size() != 0) $display("FAIL empty%0d_strobes: got %0d, need 0", i, cap3.size() + cap2.size()); else passed++;
        end
    endtask

    task automatic test_reset_midfill();
        int n, k, cyc, d; logic ba, bd;
        @(negedge clk);
        x = 9'd10; y = 9'd20; w = 9'd3; h = 9'd2; color = 24'hFC003C;
        cap3.delete(); start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        k = 0;
        while (cap3.size() < 21 && k < 400) begin @(negedge clk); k++; end
        checks++; if (cap3.size() < 21) $display("FAIL rst_reach_pixel4: got %0d bytes, need 21", cap3.size()); else passed++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy3, done3, tft_transmit3, tft_dc3, tft_data3} !== 12'h000) $display("FAIL rst_async_outputs: got %h, need 000", {busy3, done3, tft_transmit3, tft_dc3, tft_data3});
        else passed++;
        repeat (3) @(negedge clk);
        n = cap3.size();
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (cap3.size() != n || busy3 !== 1'b0) $display("FAIL rst_no_strobe: got %0d extra bytes busy=%b, need 0/0", cap3.size() - n, busy3); else passed++;
        do_fill(3, 40, 50, 2, 3, 24'h0A0B0C, cyc, ba, bd);
        exp_q.delete(); build_exp(40, 50, 2, 3, 24'h0A0B0C, 3);
        d = qdiff(3);
        checks++; if (cyc < 0 || d != -1) $display("FAIL rst_refill: cyc=%0d first diff at %0d, need done and -1", cyc, d); else passed++;
    endtask

    task automatic test_back_to_back();
        int k, na, na_exp, d;
        @(negedge clk);
        x = 9'd5; y = 9'd7; w = 9'd2; h = 9'd2; color = 24'h123456;
        cap3.delete(); start3 = 1'b1;
        @(negedge clk);
        x = 9'd100; y = 9'd50; w = 9'd3; h = 9'd1; color = 24'hABCDEF;
        k = 0;
        while (!done3 && k < 500) begin @(negedge clk); k++; end
        na = cap3.size();
        @(negedge clk);
        checks++; if (busy3 !== 1'b1) $display("FAIL b2b_restart: busy got %b, need 1", busy3); else passed++;
        start3 = 1'b0;
        x = 9'd1; y = 9'd1; w = 9'd9; color = 24'h000000;
        k = 0;
        while (!done3 && k < 500) begin @(negedge clk); k++; end
        checks++; if (!done3) $display("FAIL b2b_timeout: second done missing"); else passed++;
        exp_q.delete(); build_exp(5, 7, 2, 2, 24'h123456, 3);
        na_exp = exp_q.size();
        build_exp(100, 50, 3, 1, 24'hABCDEF, 3);
        checks++; if (na != na_exp) $display("FAIL b2b_first_len: got %0d, need %0d", na, na_exp); else passed++;
        d = qdiff(3);
        checks++; if (d != -1) $display("FAIL b2b_bytes: first diff at %0d, got %0d bytes, need %0d", d, cap3.size(), exp_q.size()); else passed++;
    endtask

    task automatic test_random();
        int cyc, d, sel, fx, fy, fw, fh; logic ba, bd; logic [23:0] c;
        for (int i = 0; i < 10; i++) begin
            sel = (i % 3 == 2) ? 2 : 3;
            fx = $urandom_range(0, 335); fy = $urandom_range(0, 250);
            fw = $urandom_range(0, 12);  fh = $urandom_range(0, 8);
            c = 24'($urandom);
            do_fill(sel, fx, fy, fw, fh, c, cyc, ba, bd);
            exp_q.delete(); build_exp(fx, fy, fw, fh, c, sel);
            d = qdiff(sel);
            checks++; if (cyc < 0 || d != -1) $display("FAIL rand%0d_fill (%0d,%0d,%0d,%0d pb%0d): cyc=%0d first diff at %0d, need -1", i, fx, fy, fw, fh, sel, cyc, d); else passed++;
            checks++; if (ba !== 1'b1 || bd !== 1'b0) $display("FAIL rand%0d_busy: got %b%b, need 10", i, ba, bd); else passed++;
        end
        checks++; if (viol != 0) $display("FAIL strobe_spacing: got %0d back-to-back strobes, need 0", viol); else passed++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_case1();
        test_case2();
        test_clip();
        test_empty();
        test_reset_midfill();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
